mem_wb_stage: RTL and testbench

//  Memory stage plus MEM/WB pipeline register of the 5-stage MIPS pipeline; consumes the EX/MEM outputs (*M signals).

---
 rtl/mem_wb_stage.sv | 103 ++++++++++
 tb/tb_mem_wb_stage.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM stage + MEM/WB register: drives a req/ack data-memory port and stalls upstream while an access is pending.
// Latency: 1 cycle for ALU ops; loads/stores add 1..MAX_WAIT ACCESS cycles; StallM is combinational backpressure.
module mem_wb_stage #(
  parameter int DATA_W   = 32,
  parameter int REG_W    = 5,
  parameter int MAX_WAIT = 15
) (
  input  logic              clk,
  input  logic              Rst,
  input  logic [DATA_W-1:0] AluoutM,
  input  logic [DATA_W-1:0] writeDataM,
  input  logic [REG_W-1:0]  writeRegM,
  input  logic              RegWriteM,
  input  logic              MemtoRegM,
  input  logic              MemwriteM,
  output logic              mem_req,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              StallM,
  output logic [DATA_W-1:0] ResultW,
  output logic [REG_W-1:0]  writeRegW,
  output logic              RegWriteW,
  output logic              err_misalign,
  output logic              err_timeout
);

  typedef enum logic {IDLE, ACCESS} state_t;

  state_t     state;
  logic [7:0] cnt;
  logic       mem_access;
  logic       misaligned;
  logic       last_wait;

  assign mem_access = MemtoRegM | MemwriteM;
  assign misaligned = mem_access & (AluoutM[1:0] != 2'b00);
  assign last_wait  = (cnt == 8'(MAX_WAIT - 1));

  // Stall drops in the cycle that finishes the access (ack or abort) so the next instruction advances.
  always_comb begin
    if (state == IDLE) StallM = mem_access & ~misaligned;
    else               StallM = ~mem_ack & ~last_wait;
  end

  always_ff @(posedge clk) begin
    if (!Rst) begin
      state        <= IDLE;
      cnt          <= 8'd0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_wdata    <= '0;
      ResultW      <= '0;
      writeRegW    <= '0;
      RegWriteW    <= 1'b0;
      err_misalign <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (!mem_access) begin
            ResultW   <= AluoutM;
            writeRegW <= writeRegM;
            RegWriteW <= RegWriteM;
          end else if (misaligned) begin
            err_misalign <= 1'b1;
            RegWriteW    <= 1'b0;
          end else begin
            state     <= ACCESS;
            mem_req   <= 1'b1;
            mem_we    <= MemwriteM;
            mem_addr  <= AluoutM;
            mem_wdata <= writeDataM;
            cnt       <= 8'd0;
            RegWriteW <= 1'b0;
          end
        end
        ACCESS: begin
          if (mem_ack) begin
            state     <= IDLE;
            mem_req   <= 1'b0;
            ResultW   <= MemtoRegM ? mem_rdata : AluoutM;
            writeRegW <= writeRegM;
            RegWriteW <= RegWriteM;
          end else if (last_wait) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            err_timeout <= 1'b1;
            RegWriteW   <= 1'b0;
          end else begin
            cnt       <= cnt + 8'd1;
            RegWriteW <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: driver/memory model issues instructions, monitor scores every write-back.
module tb_mem_wb_stage;
  localparam int MAX_WAIT = 15;

  logic        clk = 1'b0;
  logic        Rst;
  logic [31:0] AluoutM, writeDataM, mem_addr, mem_wdata, mem_rdata, ResultW;
  logic [4:0]  writeRegM, writeRegW;
  logic        RegWriteM, MemtoRegM, MemwriteM;
  logic        mem_req, mem_we, mem_ack, StallM, RegWriteW, err_misalign, err_timeout;

  int total = 0;
  int bad   = 0;
  logic [36:0] wq[$];
  logic m_mis = 1'b0;
  logic m_to  = 1'b0;

  mem_wb_stage #(.DATA_W(32), .REG_W(5), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .Rst(Rst), .AluoutM(AluoutM), .writeDataM(writeDataM),
    .writeRegM(writeRegM), .RegWriteM(RegWriteM), .MemtoRegM(MemtoRegM),
    .MemwriteM(MemwriteM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .StallM(StallM), .ResultW(ResultW),
    .writeRegW(writeRegW), .RegWriteW(RegWriteW),
    .err_misalign(err_misalign), .err_timeout(err_timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every cycle with a write-back enabled must match the oldest expected write.
  initial begin
    logic [36:0] e;
    forever begin
      @(posedge clk);
      #2;
      if (Rst && RegWriteW) begin
        if (wq.size() == 0) begin
          check("unexpected_write", {27'd0, writeRegW}, 32'hFFFF_FFFF);
        end else begin
          e = wq.pop_front();
          check("ResultW", ResultW, e[31:0]);
          check("writeRegW", {27'd0, writeRegW}, {27'd0, e[36:32]});
        end
      end
    end
  end

  // One instruction through MEM; lat = ACCESS cycle carrying ack, 0 = never ack.
  task automatic issue(input logic [31:0] alu, input logic [31:0] wd, input logic [4:0] rg,
                       input logic rw, input logic mtr, input logic mw,
                       input int lat, input logic [31:0] rd);
    logic acc, mis, ack;
    AluoutM = alu; writeDataM = wd; writeRegM = rg;
    RegWriteM = rw; MemtoRegM = mtr; MemwriteM = mw; mem_ack = 1'b0;
    acc = mtr | mw;
    mis = acc && (alu[1:0] != 2'b00);
    #1;
    check("stall_issue", {31'd0, StallM}, {31'd0, acc && !mis});
    check("req_idle", {31'd0, mem_req}, 32'd0);
    check("err_misalign", {31'd0, err_misalign}, {31'd0, m_mis});
    check("err_timeout", {31'd0, err_timeout}, {31'd0, m_to});
    if (!acc) begin
      if (rw) wq.push_back({rg, alu});
      step();
    end else if (mis) begin
      m_mis = 1'b1;
      step();
    end else begin
      step();
      for (int k = 1; k <= MAX_WAIT; k++) begin
        ack = (k == lat);
        mem_ack = ack;
        mem_rdata = rd;
        if (ack && rw) wq.push_back({rg, mtr ? rd : alu});
        #1;
        check("mem_req", {31'd0, mem_req}, 32'd1);
        check("mem_we", {31'd0, mem_we}, {31'd0, mw});
        check("mem_addr", mem_addr, alu);
        check("mem_wdata", mem_wdata, wd);
        check("stall_access", {31'd0, StallM}, {31'd0, !(ack || k == MAX_WAIT)});
        step();
        mem_ack = 1'b0;
        if (ack) break;
        if (k == MAX_WAIT) m_to = 1'b1;
      end
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_ResultW"}, ResultW, 32'd0);
    check({tag, "_writeRegW"}, {27'd0, writeRegW}, 32'd0);
    check({tag, "_RegWriteW"}, {31'd0, RegWriteW}, 32'd0);
    check({tag, "_errs"}, {30'd0, err_misalign, err_timeout}, 32'd0);
  endtask

  initial begin
    logic [31:0] a, d, r;
    int kind, lat, sel;
    Rst = 1'b0; AluoutM = 32'd0; writeDataM = 32'd0; writeRegM = 5'd0;
    RegWriteM = 1'b0; MemtoRegM = 1'b0; MemwriteM = 1'b0;
    mem_ack = 1'b0; mem_rdata = 32'd0;
    step(); step();
    check_zero("reset");
    Rst = 1'b1;

    issue(32'h1234, 32'd0, 5'd5, 1'b1, 1'b0, 1'b0, 0, 32'd0);
    issue(32'h100, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3, 32'hDEAD_BEEF);
    issue(32'h40, 32'hA5A5_A5A5, 5'd0, 1'b0, 1'b0, 1'b1, 1, 32'd0);
    issue(32'h200, 32'd0, 5'd9, 1'b1, 1'b1, 1'b0, 0, 32'd0);
    issue(32'h102, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1, 32'd0);
    issue(32'h300, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, MAX_WAIT, 32'h0BAD_F00D);

    for (int n = 0; n < 150; n++) begin
      kind = $urandom_range(0, 2);
      a = $urandom;
      d = $urandom;
      r = $urandom;
      sel = $urandom_range(0, 9);
      if (sel >= 2) a[1:0] = 2'b00;
      sel = $urandom_range(0, 9);
      lat = (sel == 0) ? 0 : (sel == 1) ? MAX_WAIT : $urandom_range(1, 4);
      case (kind)
        0:       issue(a, d, 5'($urandom), 1'($urandom), 1'b0, 1'b0, 0, r);
        1:       issue(a, d, 5'($urandom), 1'b1, 1'b1, 1'b0, lat, r);
        default: issue(a, d, 5'($urandom), 1'b0, 1'b0, 1'b1, lat, r);
      endcase
    end

    // Reset in the middle of an access, then a stray ack must not write back.
    AluoutM = 32'h500; writeRegM = 5'd11; RegWriteM = 1'b1; MemtoRegM = 1'b1; MemwriteM = 1'b0;
    step(); step();
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    AluoutM = 32'h0; RegWriteM = 1'b0; MemtoRegM = 1'b0;
    m_mis = 1'b0; m_to = 1'b0;
    #1;
    check_zero("midreset");
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    #1;
    check("stall_late_ack", {31'd0, StallM}, 32'd0);
    step();
    mem_ack = 1'b0;
    check("late_ack_RegWriteW", {31'd0, RegWriteW}, 32'd0);
    check("late_ack_req", {31'd0, mem_req}, 32'd0);

    step(); step();
    check("queue_drained", wq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
